// File: rtl/issue_select_pipe_pkg.sv
// Shared types and helpers for the issue-select pipeline.
package issue_pkg;

   typedef enum logic [1:0] {
      FU_ALU    = 2'd0,
      FU_MEM    = 2'd1,
      FU_BR     = 2'd2,
      FU_MULDIV = 2'd3
   } fu_class_e;

   // Distance from the ROB head, modulo the ROB size; smaller means older.
   function automatic logic [31:0] rob_age(input logic [31:0] idx,
                                           input logic [31:0] head,
                                           input int          w);
      logic [31:0] diff;
      diff = idx - head;
      return diff & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/issue_select_pipe_picker.sv
// One-hot grant of the oldest requesting candidate; ties go to the lower index.
module oldest_picker
   import issue_pkg::*;
#(
   parameter int N         = 4,
   parameter int ROB_IDX_W = 7
) (
   input  logic [N-1:0]           req_i,
   input  logic [N*ROB_IDX_W-1:0] rob_idx_i,
   input  logic [ROB_IDX_W-1:0]   rob_head_i,
   output logic [N-1:0]           grant_o
);

   logic        found;
   logic [31:0] age;
   logic [31:0] best_age;

   always_comb begin
      grant_o  = '0;
      found    = 1'b0;
      age      = '0;
      best_age = '0;
      for (int i = 0; i < N; i++) begin
         age = rob_age(32'(rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W]), 32'(rob_head_i), ROB_IDX_W);
         // Strict less-than keeps the lower index on equal age.
         if (req_i[i] && (!found || age < best_age)) begin
            grant_o     = '0;
            grant_o[i]  = 1'b1;
            found       = 1'b1;
            best_age    = age;
         end
      end
   end

endmodule

// File: rtl/issue_select_pipe.sv
// Issue stage: oldest-first selection of ready candidates into per-class FU slots,
// with registered slot outputs, MULDIV occupancy countdown and flush.
module issue_select_pipe
   import issue_pkg::*;
#(
   parameter int NUM_CAND   = 4,
   parameter int NUM_ALU    = 2,
   parameter int NUM_MEM    = 1,
   parameter int NUM_BRANCH = 1,
   parameter int ROB_IDX_W  = 7,
   parameter int PAYLOAD_W  = 160,
   parameter int MULDIV_LAT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [ROB_IDX_W-1:0]            rob_head,
   input  logic [NUM_CAND-1:0]             cand_valid,
   input  logic [2*NUM_CAND-1:0]           cand_class,
   input  logic [NUM_CAND*ROB_IDX_W-1:0]   cand_rob_idx,
   input  logic [NUM_CAND*PAYLOAD_W-1:0]   cand_payload,
   output logic [NUM_CAND-1:0]             cand_ack,
   output logic [NUM_ALU-1:0]              alu_valid,
   output logic [NUM_ALU*ROB_IDX_W-1:0]    alu_rob_idx,
   output logic [NUM_ALU*PAYLOAD_W-1:0]    alu_payload,
   input  logic [NUM_ALU-1:0]              alu_ready,
   output logic [NUM_MEM-1:0]              mem_valid,
   output logic [NUM_MEM*ROB_IDX_W-1:0]    mem_rob_idx,
   output logic [NUM_MEM*PAYLOAD_W-1:0]    mem_payload,
   input  logic [NUM_MEM-1:0]              mem_ready,
   output logic [NUM_BRANCH-1:0]           br_valid,
   output logic [NUM_BRANCH*ROB_IDX_W-1:0] br_rob_idx,
   output logic [NUM_BRANCH*PAYLOAD_W-1:0] br_payload,
   input  logic [NUM_BRANCH-1:0]           br_ready,
   output logic                            md_valid,
   output logic [ROB_IDX_W-1:0]            md_rob_idx,
   output logic [PAYLOAD_W-1:0]            md_payload,
   input  logic                            md_ready,
   output logic                            md_busy,
   output logic [31:0]                     issue_count
);

   localparam int NUM_SLOTS = NUM_ALU + NUM_MEM + NUM_BRANCH + 1;
   localparam int MEM_BASE  = NUM_ALU;
   localparam int BR_BASE   = NUM_ALU + NUM_MEM;
   localparam int MD_SLOT   = NUM_SLOTS - 1;
   localparam int CNT_W     = $clog2(MULDIV_LAT + 1);

   logic [NUM_SLOTS-1:0] slot_valid;
   logic [NUM_SLOTS-1:0] slot_ready;
   logic [NUM_SLOTS-1:0] slot_free;
   logic [ROB_IDX_W-1:0] slot_rob [NUM_SLOTS];
   logic [PAYLOAD_W-1:0] slot_pl  [NUM_SLOTS];
   logic [NUM_CAND-1:0]  grant    [NUM_SLOTS];
   logic [NUM_CAND-1:0]  taken    [NUM_SLOTS+1];
   logic [NUM_CAND-1:0]  cand_live;

   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]      issue_cnt_q, issue_cnt_d;
   logic [31:0]      handoffs;

   assign cand_live  = cand_valid & ~{NUM_CAND{rst | flush}};
   assign slot_ready = {md_ready, br_ready, mem_ready, alu_ready};
   assign taken[0]   = '0;
   assign cand_ack   = taken[NUM_SLOTS];

   // Slots form one chain in ALU, MEM, BR, MULDIV order; each strips its grant from later slots.
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         localparam fu_class_e SLOT_CLASS =
            (gi < MEM_BASE) ? FU_ALU :
            (gi < BR_BASE)  ? FU_MEM :
            (gi < MD_SLOT)  ? FU_BR  : FU_MULDIV;

         logic [NUM_CAND-1:0]  class_mask;
         logic [NUM_CAND-1:0]  req;
         logic [ROB_IDX_W-1:0] rob_sel;
         logic [PAYLOAD_W-1:0] pl_sel;
         logic                 valid_q;
         logic [ROB_IDX_W-1:0] rob_q;
         logic [PAYLOAD_W-1:0] pl_q;

         always_comb begin
            class_mask = '0;
            for (int c = 0; c < NUM_CAND; c++) begin
               class_mask[c] = cand_live[c] && (fu_class_e'(cand_class[2*c +: 2]) == SLOT_CLASS);
            end
         end

         if (gi == MD_SLOT) begin : g_md_free
            // A handoff restarts the countdown, so a draining MULDIV slot is not refillable.
            assign slot_free[gi] = !valid_q && (md_cnt_q == '0);
         end else begin : g_pipe_free
            assign slot_free[gi] = !valid_q || slot_ready[gi];
         end

         assign req = class_mask & ~taken[gi] & {NUM_CAND{slot_free[gi]}};

         oldest_picker #(
            .N         (NUM_CAND),
            .ROB_IDX_W (ROB_IDX_W)
         ) u_pick (
            .req_i      (req),
            .rob_idx_i  (cand_rob_idx),
            .rob_head_i (rob_head),
            .grant_o    (grant[gi])
         );

         assign taken[gi+1] = taken[gi] | grant[gi];

         always_comb begin
            rob_sel = '0;
            pl_sel  = '0;
            for (int c = 0; c < NUM_CAND; c++) begin
               if (grant[gi][c]) begin
                  rob_sel = cand_rob_idx[c*ROB_IDX_W +: ROB_IDX_W];
                  pl_sel  = cand_payload[c*PAYLOAD_W +: PAYLOAD_W];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               rob_q   <= '0;
               pl_q    <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
            end else if (|grant[gi]) begin
               valid_q <= 1'b1;
               rob_q   <= rob_sel;
               pl_q    <= pl_sel;
            end else if (slot_ready[gi]) begin
               valid_q <= 1'b0;
            end
         end

         assign slot_valid[gi] = valid_q;
         assign slot_rob[gi]   = rob_q;
         assign slot_pl[gi]    = pl_q;
      end

      for (genvar gi = 0; gi < NUM_ALU; gi++) begin : g_alu_out
         assign alu_valid[gi]                          = slot_valid[gi];
         assign alu_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W] = slot_rob[gi];
         assign alu_payload[gi*PAYLOAD_W +: PAYLOAD_W] = slot_pl[gi];
      end

      for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem_out
         assign mem_valid[gi]                          = slot_valid[MEM_BASE+gi];
         assign mem_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W] = slot_rob[MEM_BASE+gi];
         assign mem_payload[gi*PAYLOAD_W +: PAYLOAD_W] = slot_pl[MEM_BASE+gi];
      end

      for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_br_out
         assign br_valid[gi]                          = slot_valid[BR_BASE+gi];
         assign br_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W] = slot_rob[BR_BASE+gi];
         assign br_payload[gi*PAYLOAD_W +: PAYLOAD_W] = slot_pl[BR_BASE+gi];
      end
   endgenerate

   assign md_valid    = slot_valid[MD_SLOT];
   assign md_rob_idx  = slot_rob[MD_SLOT];
   assign md_payload  = slot_pl[MD_SLOT];
   assign md_busy     = (md_cnt_q != '0);
   assign issue_count = issue_cnt_q;

   always_comb begin
      handoffs = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         handoffs = handoffs + 32'(slot_valid[s] && slot_ready[s]);
      end
      issue_cnt_d = issue_cnt_q + handoffs;

      md_cnt_d = md_cnt_q;
      if (flush) begin
         md_cnt_d = '0;
      end else if (slot_valid[MD_SLOT] && md_ready) begin
         md_cnt_d = CNT_W'(MULDIV_LAT);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q    <= '0;
         issue_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

endmodule

// File: tb/tb_issue_select_pipe.sv
// Directed bench for issue_select_pipe: table of single-cycle selection vectors
// followed by hand-written backpressure, MULDIV, flush and mixed-class sequences.
module tb_issue_select_pipe;
   import issue_pkg::*;

   localparam int NC = 4;
   localparam int RW = 7;
   localparam int PW = 160;

   logic           clk = 1'b0;
   logic           rst, flush;
   logic [RW-1:0]  rob_head;
   logic [NC-1:0]  cand_valid;
   logic [2*NC-1:0]  cand_class;
   logic [NC*RW-1:0] cand_rob_idx;
   logic [NC*PW-1:0] cand_payload;
   logic [NC-1:0]  cand_ack;
   logic [1:0]     alu_valid;
   logic [2*RW-1:0] alu_rob_idx;
   logic [2*PW-1:0] alu_payload;
   logic [1:0]     alu_ready;
   logic           mem_valid, mem_ready, br_valid, br_ready, md_valid, md_ready, md_busy;
   logic [RW-1:0]  mem_rob_idx, br_rob_idx, md_rob_idx;
   logic [PW-1:0]  mem_payload, br_payload, md_payload;
   logic [31:0]    issue_count;

   int checks   = 0;
   int failures = 0;
   int exp_issue = 0;

   issue_select_pipe dut (
      .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
      .cand_valid(cand_valid), .cand_class(cand_class), .cand_rob_idx(cand_rob_idx),
      .cand_payload(cand_payload), .cand_ack(cand_ack),
      .alu_valid(alu_valid), .alu_rob_idx(alu_rob_idx), .alu_payload(alu_payload), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rob_idx(mem_rob_idx), .mem_payload(mem_payload), .mem_ready(mem_ready),
      .br_valid(br_valid), .br_rob_idx(br_rob_idx), .br_payload(br_payload), .br_ready(br_ready),
      .md_valid(md_valid), .md_rob_idx(md_rob_idx), .md_payload(md_payload), .md_ready(md_ready),
      .md_busy(md_busy), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] head;
      logic [3:0]    vld;
      logic [7:0]    cls;   // cand3..cand0, 2 bits each
      logic [27:0]   rob;   // cand3..cand0, 7 bits each
      logic [3:0]    ack;
      logic [1:0]    alu_v;
      logic [RW-1:0] alu0;
      logic [RW-1:0] alu1;
      logic          mem_v;
      logic [RW-1:0] mem;
      logic          br_v;
      logic [RW-1:0] br;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [PW-1:0] mk_pl(input logic [RW-1:0] r);
      return {25'h1ABCDEF, r, 64'hDEAD_BEEF_CAFE_F00D ^ {57'd0, r}, 57'h0, r};
   endfunction

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic set_cand(input int i, input logic v, input logic [1:0] c, input logic [RW-1:0] r);
      cand_valid[i]            = v;
      cand_class[2*i +: 2]     = c;
      cand_rob_idx[i*RW +: RW] = r;
      cand_payload[i*PW +: PW] = mk_pl(r);
   endtask

   task automatic clear_cands();
      cand_valid = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            head  vld      cls           rob {c3,c2,c1,c0}              ack      aluv   a0   a1  memv mem brv br
      tbl[0] = '{7'd10,  4'b1111, 8'b00_00_00_00, {7'd10, 7'd12, 7'd11, 7'd13}, 4'b1010, 2'b11, 7'd10, 7'd11, 1'b0, 7'd0, 1'b0, 7'd0};
      tbl[1] = '{7'd126, 4'b0111, 8'b00_00_00_00, {7'd5, 7'd0, 7'd127, 7'd1},   4'b0110, 2'b11, 7'd127, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0};
      tbl[2] = '{7'd0,   4'b0111, 8'b00_00_00_00, {7'd9, 7'd5, 7'd5, 7'd5},     4'b0011, 2'b11, 7'd5, 7'd5,   1'b0, 7'd0, 1'b0, 7'd0};
      tbl[3] = '{7'd0,   4'b0000, 8'b00_00_00_00, {7'd1, 7'd2, 7'd3, 7'd4},     4'b0000, 2'b00, 7'd0, 7'd0,   1'b0, 7'd0, 1'b0, 7'd0};
      tbl[4] = '{7'd20,  4'b1111, 8'b10_10_01_01, {7'd22, 7'd30, 7'd21, 7'd25}, 4'b1010, 2'b00, 7'd0, 7'd0,   1'b1, 7'd21, 1'b1, 7'd22};
      tbl[5] = '{7'd100, 4'b1111, 8'b01_00_00_00, {7'd3, 7'd100, 7'd101, 7'd99}, 4'b1110, 2'b11, 7'd100, 7'd101, 1'b1, 7'd3, 1'b0, 7'd0};
      tbl[6] = '{7'd0,   4'b0001, 8'b00_01_01_00, {7'd1, 7'd2, 7'd3, 7'd7},     4'b0001, 2'b01, 7'd7, 7'd0,   1'b0, 7'd0, 1'b0, 7'd0};
      tbl[7] = '{7'd127, 4'b0111, 8'b00_00_10_10, {7'd1, 7'd126, 7'd0, 7'd127}, 4'b0101, 2'b01, 7'd126, 7'd0, 1'b0, 7'd0, 1'b1, 7'd127};

      rst = 1'b1; flush = 1'b0; rob_head = '0;
      cand_valid = '0; cand_class = '0; cand_rob_idx = '0; cand_payload = '0;
      alu_ready = '0; mem_ready = 1'b0; br_ready = 1'b0; md_ready = 1'b0;

      // Reset: ack suppressed while rst is high, state cleared afterwards.
      tick();
      for (int i = 0; i < NC; i++) set_cand(i, 1'b1, FU_ALU, RW'(i));
      #1;
      chk("rst_ack", PW'(cand_ack), PW'(4'b0000));
      tick();
      rst = 1'b0;
      clear_cands();
      chk("rst_alu_valid", PW'(alu_valid), PW'(0));
      chk("rst_alu_payload", alu_payload[PW-1:0], PW'(0));
      chk("rst_mem_br_md_valid", PW'({mem_valid, br_valid, md_valid}), PW'(0));
      chk("rst_md_busy", PW'(md_busy), PW'(0));
      chk("rst_issue_count", PW'(issue_count), PW'(0));

      // Table phase: every slot ready, so each row's slots drain in the following row.
      alu_ready = 2'b11; mem_ready = 1'b1; br_ready = 1'b1; md_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         rob_head = tbl[r].head;
         for (int i = 0; i < NC; i++) begin
            set_cand(i, tbl[r].vld[i], tbl[r].cls[2*i +: 2], tbl[r].rob[i*RW +: RW]);
         end
         #1;
         chk($sformatf("row%0d_ack", r), PW'(cand_ack), PW'(tbl[r].ack));
         tick();
         chk($sformatf("row%0d_alu_valid", r), PW'(alu_valid), PW'(tbl[r].alu_v));
         chk($sformatf("row%0d_mem_valid", r), PW'(mem_valid), PW'(tbl[r].mem_v));
         chk($sformatf("row%0d_br_valid", r), PW'(br_valid), PW'(tbl[r].br_v));
         if (tbl[r].alu_v[0]) begin
            chk($sformatf("row%0d_alu0_rob", r), PW'(alu_rob_idx[RW-1:0]), PW'(tbl[r].alu0));
            chk($sformatf("row%0d_alu0_pl", r), alu_payload[PW-1:0], mk_pl(tbl[r].alu0));
         end
         if (tbl[r].alu_v[1]) chk($sformatf("row%0d_alu1_rob", r), PW'(alu_rob_idx[2*RW-1:RW]), PW'(tbl[r].alu1));
         if (tbl[r].mem_v) chk($sformatf("row%0d_mem_rob", r), PW'(mem_rob_idx), PW'(tbl[r].mem));
         if (tbl[r].br_v) chk($sformatf("row%0d_br_rob", r), PW'(br_rob_idx), PW'(tbl[r].br));
         exp_issue += int'(tbl[r].alu_v[0]) + int'(tbl[r].alu_v[1]) + int'(tbl[r].mem_v) + int'(tbl[r].br_v);
      end
      clear_cands();
      tick();
      chk("table_issue_count", PW'(issue_count), PW'(exp_issue));
      chk("table_drained", PW'({alu_valid, mem_valid, br_valid}), PW'(0));

      // Backpressure on the MEM slot.
      rob_head = 7'd40; mem_ready = 1'b0;
      set_cand(0, 1'b1, FU_MEM, 7'd40);
      #1; chk("bp_first_ack", PW'(cand_ack), PW'(4'b0001));
      tick();
      set_cand(0, 1'b1, FU_MEM, 7'd41);
      #1; chk("bp_blocked_ack", PW'(cand_ack), PW'(4'b0000));
      tick();
      chk("bp_hold_rob", PW'(mem_rob_idx), PW'(7'd40));
      chk("bp_hold_pl", mem_payload, mk_pl(7'd40));
      mem_ready = 1'b1;
      #1; chk("bp_release_ack", PW'(cand_ack), PW'(4'b0001));
      tick();
      exp_issue += 1;
      chk("bp_new_rob", PW'(mem_rob_idx), PW'(7'd41));
      chk("bp_new_pl", mem_payload, mk_pl(7'd41));
      clear_cands();
      tick();
      exp_issue += 1;
      chk("bp_issue_count", PW'(issue_count), PW'(exp_issue));

      // MULDIV occupancy: busy for MULDIV_LAT cycles after handoff, next ack only once idle.
      rob_head = 7'd50; md_ready = 1'b0;
      set_cand(0, 1'b1, FU_MULDIV, 7'd50);
      #1; chk("md_first_ack", PW'(cand_ack), PW'(4'b0001));
      tick();
      md_ready = 1'b1;
      set_cand(0, 1'b1, FU_MULDIV, 7'd51);
      #1;
      chk("md_handoff_busy", PW'(md_busy), PW'(0));
      chk("md_handoff_ack", PW'(cand_ack), PW'(4'b0000));
      tick();
      exp_issue += 1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("md_busy_c%0d", k), PW'(md_busy), PW'(1));
         chk($sformatf("md_ack_c%0d", k), PW'(cand_ack), PW'(4'b0000));
         tick();
      end
      chk("md_idle_busy", PW'(md_busy), PW'(0));
      chk("md_idle_ack", PW'(cand_ack), PW'(4'b0001));
      tick();
      chk("md_second_valid", PW'(md_valid), PW'(1));
      chk("md_second_rob", PW'(md_rob_idx), PW'(7'd51));
      chk("md_second_pl", md_payload, mk_pl(7'd51));

      // Flush with three occupied slots and the MULDIV unit busy.
      clear_cands();
      alu_ready = 2'b00; mem_ready = 1'b0; br_ready = 1'b0;
      rob_head = 7'd60;
      set_cand(0, 1'b1, FU_ALU, 7'd60);
      set_cand(1, 1'b1, FU_MEM, 7'd61);
      set_cand(2, 1'b1, FU_BR, 7'd62);
      #1; chk("fl_setup_ack", PW'(cand_ack), PW'(4'b0111));
      tick();
      exp_issue += 1;
      clear_cands();
      chk("fl_setup_valids", PW'({alu_valid, mem_valid, br_valid}), PW'(4'b0111));
      chk("fl_setup_busy", PW'(md_busy), PW'(1));
      flush = 1'b1; alu_ready = 2'b01;
      set_cand(0, 1'b1, FU_ALU, 7'd63);
      #1; chk("fl_ack", PW'(cand_ack), PW'(4'b0000));
      tick();
      exp_issue += 1;
      flush = 1'b0;
      clear_cands();
      chk("fl_valids", PW'({alu_valid, mem_valid, br_valid, md_valid}), PW'(0));
      chk("fl_busy", PW'(md_busy), PW'(0));
      chk("fl_issue_count", PW'(issue_count), PW'(exp_issue));

      // Mixed classes into empty slots, then a single all-ready handoff cycle.
      alu_ready = 2'b00; md_ready = 1'b0;
      rob_head = 7'd70;
      set_cand(0, 1'b1, FU_ALU, 7'd70);
      set_cand(1, 1'b1, FU_MEM, 7'd71);
      set_cand(2, 1'b1, FU_BR, 7'd72);
      set_cand(3, 1'b1, FU_MULDIV, 7'd73);
      #1; chk("mix_ack", PW'(cand_ack), PW'(4'b1111));
      tick();
      clear_cands();
      chk("mix_valids", PW'({alu_valid, mem_valid, br_valid, md_valid}), PW'(5'b01111));
      chk("mix_robs", PW'({alu_rob_idx[RW-1:0], mem_rob_idx, br_rob_idx, md_rob_idx}),
          PW'({7'd70, 7'd71, 7'd72, 7'd73}));
      alu_ready = 2'b11; mem_ready = 1'b1; br_ready = 1'b1; md_ready = 1'b1;
      tick();
      exp_issue += 4;
      chk("mix_issue_count", PW'(issue_count), PW'(exp_issue));
      chk("mix_drained", PW'({alu_valid, mem_valid, br_valid, md_valid}), PW'(0));
      chk("mix_md_busy", PW'(md_busy), PW'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
